// File: rtl/axi_burst_master_if.sv
// axi_burst_master_if: command, write/read stream and AXI channel signals of the burst master.
interface axi_burst_master_if #(parameter int ADDR_WIDTH = 5, parameter int DATA_WIDTH = 32);
    logic                  cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [7:0]            cmd_len;
    logic                  wr_valid, wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid, rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy, done, error;
    logic                  AWVALID, AWREADY, AWBURST;
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic                  WVALID, WREADY, WLAST;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  BVALID, BREADY;
    logic [1:0]            BRESP;
    logic                  ARVALID, ARREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic                  RVALID, RREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  W_EN, R_EN;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
               AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, error,
               AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY,
               ARVALID, ARADDR, RREADY, W_EN, R_EN
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
               AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RDATA, RRESP,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, error,
               AWVALID, AWADDR, AWBURST, AWLEN, WVALID, WDATA, WLAST, BREADY,
               ARVALID, ARADDR, RREADY, W_EN, R_EN
    );
endinterface

// File: rtl/axi_burst_master.sv
// axi_burst_master: writes one INCR burst or reads N words as single-beat AR/R pairs,
// bridging a write stream and a read stream to the AXI channels.
module axi_burst_master #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic ACLK,
    input logic ARESET,
    axi_burst_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, AW_REQ, W_DATA, B_RESP, AR_REQ, R_DATA, RD_OUT, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [8:0]            beat_q, beat_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  last_beat;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign last_beat = beat_q == {1'b0, len_q} - 9'd1;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (bus.cmd_valid) begin
                addr_d  = bus.cmd_addr;
                len_d   = bus.cmd_len;
                beat_d  = '0;
                err_d   = 1'b0;
                state_d = (bus.cmd_len == 8'd0) ? DONE : (bus.cmd_write ? AW_REQ : AR_REQ);
            end
            AW_REQ: state_d = bus.AWREADY ? W_DATA : AW_REQ;
            W_DATA: if (bus.wr_valid && bus.WREADY) begin
                beat_d  = beat_q + 9'd1;
                state_d = last_beat ? B_RESP : W_DATA;
            end
            B_RESP: if (bus.BVALID) begin
                err_d   = err_q | (bus.BRESP != 2'b00);
                state_d = DONE;
            end
            AR_REQ: state_d = bus.ARREADY ? R_DATA : AR_REQ;
            R_DATA: if (bus.RVALID) begin
                rdata_d = bus.RDATA;
                err_d   = err_q | (bus.RRESP != 2'b00);
                state_d = RD_OUT;
            end
            // Address advances only once the word has left on the read stream.
            RD_OUT: if (bus.rd_ready) begin
                addr_d  = addr_q + ADDR_WIDTH'(1);
                beat_d  = beat_q + 9'd1;
                state_d = (beat_q + 9'd1 == {1'b0, len_q}) ? DONE : AR_REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.error     = (state_q == DONE) & err_q;
    assign bus.AWVALID   = state_q == AW_REQ;
    assign bus.AWADDR    = addr_q;
    assign bus.AWLEN     = len_q;
    assign bus.AWBURST   = 1'b1;
    assign bus.WVALID    = (state_q == W_DATA) & bus.wr_valid;
    assign bus.WDATA     = (state_q == W_DATA) ? bus.wr_data : '0;
    assign bus.WLAST     = (state_q == W_DATA) & last_beat;
    assign bus.wr_ready  = (state_q == W_DATA) & bus.WREADY;
    assign bus.BREADY    = state_q == B_RESP;
    assign bus.ARVALID   = state_q == AR_REQ;
    assign bus.ARADDR    = addr_q;
    assign bus.RREADY    = state_q == R_DATA;
    assign bus.rd_valid  = state_q == RD_OUT;
    assign bus.rd_data   = rdata_q;
    assign bus.W_EN      = (state_q == AW_REQ) | (state_q == W_DATA) | (state_q == B_RESP);
    assign bus.R_EN      = (state_q == AR_REQ) | (state_q == R_DATA) | (state_q == RD_OUT);
endmodule

// File: tb/tb_axi_burst_master.sv
// tb_axi_burst_master: drives commands, plays AXI slave and stream endpoints, and checks
// transfers against a word-addressed memory model of what each command should do.
module tb_axi_burst_master;
    localparam int AW = 5, DW = 32, MEM = 1 << AW;

    logic ACLK = 1'b0, ARESET = 1'b1;
    int   checks = 0, errors = 0;

    axi_burst_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.ACLK(ACLK), .ARESET(ARESET), .bus(bus));

    always #5 ACLK = ~ACLK;

    logic [DW-1:0] slave_mem [MEM];
    logic [DW-1:0] ref_mem [MEM];
    logic [DW-1:0] wdata [256];

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        int            len;
        int            mode;
        int            cycles;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
        bus.wr_valid = 0; bus.wr_data = 0; bus.rd_ready = 0;
        bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
        bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
    endtask

    task automatic run_cmd(input logic wr, input logic [AW-1:0] addr, input int len, input int mode,
                           input logic [1:0] bresp, input int rerr, input bit stall,
                           input int abort_at, input int exp_cyc);
        int ws, wc, awc, bc, arc, rc, rdc, s_aw;
        bit acc, pend_b, pend_r, fin, saw_valid, aw_st, ar_st, rd_st;
        logic [AW-1:0] aw_a, ar_a, r_a;
        logic [DW-1:0] rd_d;
        logic exp_err;
        ws = 0; wc = 0; awc = 0; bc = 0; arc = 0; rc = 0; rdc = 0; s_aw = 0;
        acc = 0; pend_b = 0; pend_r = 0; fin = 0; saw_valid = 0; aw_st = 0; ar_st = 0; rd_st = 0;
        aw_a = 0; ar_a = 0; r_a = 0; rd_d = 0;
        exp_err = wr ? (bresp != 2'b00) : (rerr >= 0 && rerr < len);
        for (int i = 0; i < len; i++) wdata[i] = (mode == 0) ? DW'(i * i) : $urandom;
        for (int cyc = 0; cyc < 2000 && !fin; cyc++) begin
            @(negedge ACLK);
            if (abort_at >= 0 && wc == abort_at) begin
                idle_inputs();
                ARESET = 1;
                @(negedge ACLK);
                ARESET = 0;
                #1;
                chk("abort_cmd_ready", bus.cmd_ready, 1);
                chk("abort_busy", bus.busy, 0);
                chk("abort_outs", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY,
                                   bus.rd_valid, bus.W_EN, bus.done}, 0);
                for (int i = 0; i < abort_at; i++) ref_mem[(int'(addr) + i) % MEM] = wdata[i];
                return;
            end
            if (!acc) begin
                bus.cmd_valid = 1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_len = 8'(len);
            end else begin
                bus.cmd_valid = 1'($urandom); bus.cmd_write = 1'($urandom);
                bus.cmd_addr = AW'($urandom); bus.cmd_len = 8'($urandom);
            end
            bus.wr_valid = wr && acc && ws < len && (bus.wr_valid || !stall || $urandom_range(1, 0) == 1);
            bus.wr_data  = (ws < len) ? wdata[ws & 255] : '0;
            bus.rd_ready = !stall || $urandom_range(1, 0) == 1;
            bus.AWREADY  = !stall || $urandom_range(1, 0) == 1;
            bus.WREADY   = !stall || $urandom_range(1, 0) == 1;
            bus.ARREADY  = !stall || $urandom_range(1, 0) == 1;
            if (!pend_b) bus.BVALID = 0;
            else if (!bus.BVALID) bus.BVALID = !stall || $urandom_range(1, 0) == 1;
            bus.BRESP = bresp;
            if (!pend_r) bus.RVALID = 0;
            else if (!bus.RVALID) begin
                bus.RVALID = !stall || $urandom_range(1, 0) == 1;
                bus.RDATA  = slave_mem[r_a];
                bus.RRESP  = (rc == rerr) ? 2'b10 : 2'b00;
            end
            #1;
            saw_valid |= bus.AWVALID | bus.WVALID | bus.ARVALID;
            if (aw_st) begin chk("aw_hold", bus.AWVALID, 1); chk("aw_stable", bus.AWADDR, aw_a); end
            if (ar_st) begin chk("ar_hold", bus.ARVALID, 1); chk("ar_stable", bus.ARADDR, ar_a); end
            if (rd_st) begin chk("rd_hold", bus.rd_valid, 1); chk("rd_stable", bus.rd_data, rd_d); end
            aw_st = bus.AWVALID & !bus.AWREADY; aw_a = bus.AWADDR;
            ar_st = bus.ARVALID & !bus.ARREADY; ar_a = bus.ARADDR;
            rd_st = bus.rd_valid & !bus.rd_ready; rd_d = bus.rd_data;
            if (bus.AWVALID | bus.WVALID | bus.BREADY) chk("w_en", bus.W_EN, 1);
            if (bus.ARVALID | bus.RREADY | bus.rd_valid) chk("r_en", bus.R_EN, 1);
            if (bus.WVALID && awc == 0) chk("w_before_aw", 1, 0);
            if (cyc == 0) begin
                chk("idle_ready", bus.cmd_ready, 1);
                chk("idle_done", bus.done, 0);
            end else if (acc) begin
                chk("busy", bus.busy, 1);
                chk("cmd_ready_busy", bus.cmd_ready, 0);
            end
            if (bus.cmd_valid && bus.cmd_ready) acc = 1;
            if (bus.AWVALID && bus.AWREADY) begin
                chk("awaddr", bus.AWADDR, addr);
                chk("awlen", bus.AWLEN, len);
                chk("awburst", bus.AWBURST, 1);
                s_aw = int'(bus.AWADDR);
                awc++;
            end
            if (bus.WVALID && bus.WREADY) begin
                chk("wdata", bus.WDATA, wdata[wc & 255]);
                chk("wlast", bus.WLAST, wc == len - 1);
                chk("wr_ready", bus.wr_ready, 1);
                slave_mem[(s_aw + wc) % MEM] = bus.WDATA;
                if (bus.WLAST) pend_b = 1;
                wc++;
                ws++;
            end
            if (bus.BVALID && bus.BREADY) begin bc++; pend_b = 0; end
            if (bus.ARVALID && bus.ARREADY) begin
                chk("araddr", bus.ARADDR, (int'(addr) + arc) % MEM);
                chk("one_outstanding", arc, rdc);
                r_a = bus.ARADDR;
                pend_r = 1;
                arc++;
            end
            if (bus.RVALID && bus.RREADY) begin rc++; pend_r = 0; end
            if (bus.rd_valid && bus.rd_ready) begin
                chk("rd_data", bus.rd_data, ref_mem[(int'(addr) + rdc) % MEM]);
                rdc++;
            end
            if (bus.done) begin
                fin = 1;
                chk("error", bus.error, exp_err);
                chk("aw_count", awc, wr && len > 0);
                chk("w_count", wc, wr ? len : 0);
                chk("b_count", bc, wr && len > 0);
                chk("ar_count", arc, wr ? 0 : len);
                chk("rd_count", rdc, wr ? 0 : len);
                if (len == 0) chk("len0_no_valid", saw_valid, 0);
                if (exp_cyc >= 0) chk("latency", cyc, exp_cyc);
            end else chk("error_without_done", bus.error, 0);
        end
        if (!fin) chk("timeout", 0, 1);
        else if (wr) for (int i = 0; i < len; i++) ref_mem[(int'(addr) + i) % MEM] = wdata[i];
    endtask

    initial begin
        idle_inputs();
        for (int i = 0; i < MEM; i++) begin
            slave_mem[i] = $urandom;
            ref_mem[i]   = slave_mem[i];
        end
        vecs[0]  = '{1'b1, 5'd5,  10,  0, 13};
        vecs[1]  = '{1'b0, 5'd5,  10,  0, 31};
        vecs[2]  = '{1'b0, 5'd30, 4,   0, 13};
        vecs[3]  = '{1'b1, 5'd0,  0,   0, 1};
        vecs[4]  = '{1'b0, 5'd7,  0,   0, 1};
        vecs[5]  = '{1'b1, 5'd28, 6,   1, 9};
        vecs[6]  = '{1'b0, 5'd28, 6,   0, 19};
        vecs[7]  = '{1'b1, 5'd12, 1,   1, 4};
        vecs[8]  = '{1'b0, 5'd12, 1,   0, 4};
        vecs[9]  = '{1'b1, 5'd0,  255, 1, 258};
        vecs[10] = '{1'b0, 5'd0,  255, 0, 766};
        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy_done_err", {bus.busy, bus.done, bus.error}, 0);
        chk("rst_ctrl", {bus.AWVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.ARVALID, bus.RREADY,
                         bus.rd_valid, bus.wr_ready, bus.W_EN, bus.R_EN}, 0);
        chk("rst_awaddr", bus.AWADDR, 0);
        chk("rst_araddr", bus.ARADDR, 0);
        chk("rst_awlen", bus.AWLEN, 0);
        chk("rst_wdata", bus.WDATA, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        ARESET = 0;
        for (int v = 0; v < 11; v++)
            run_cmd(vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].mode, 2'b00, -1, 0, -1, vecs[v].cycles);
        run_cmd(1'b1, 5'd9, 12, 1, 2'b10, -1, 1, -1, -1);
        run_cmd(1'b0, 5'd9, 12, 0, 2'b00, 4, 1, -1, -1);
        run_cmd(1'b0, 5'd9, 3, 0, 2'b00, -1, 0, -1, 10);
        run_cmd(1'b1, 5'd3, 8, 1, 2'b00, -1, 0, 3, -1);
        run_cmd(1'b1, 5'd3, 8, 1, 2'b00, -1, 0, -1, 11);
        run_cmd(1'b0, 5'd3, 8, 0, 2'b00, -1, 0, -1, 25);
        repeat (25) begin
            int len;
            len = $urandom_range(20, 0);
            run_cmd(1'($urandom), AW'($urandom), len, 1, ($urandom_range(3, 0) == 0) ? 2'b10 : 2'b00,
                    ($urandom_range(3, 0) == 0) ? $urandom_range(len, 0) : -1, 1, -1, -1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
